ebpc_frame_decoder: RTL

//  Frame-level EBPC decoder front end. Per frame it merges the ZRLE zero/non-zero stream with BPC-decoded

---
 rtl/ebpc_pkg.sv | 9 +
 rtl/bpc_decoder.sv | 33 +++
 rtl/ebpc_out_reg.sv | 33 +++
 rtl/zrle_decoder.sv | 41 ++++
 rtl/ebpc_frame_decoder.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/ebpc_pkg.sv
// ebpc_pkg - shared widths and enums for the EBPC frame decoder
package ebpc_pkg;
  localparam int DATA_W        = 8;
  localparam int LOG_MAX_WORDS = 4;

  typedef enum logic {EBPC_MODE_DEC, EBPC_MODE_RAW} ebpc_mode_e;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN_EBPC, ST_RUN_RAW, ST_DONE} frame_state_e;
endpackage

// File: rtl/bpc_decoder.sv
// bpc_decoder - word-level BPC decoder: one compressed word yields one non-zero data word
module bpc_decoder #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] bpc_i,
  input  logic              bpc_vld_i,
  output logic              bpc_rdy_o,
  output logic [DATA_W-1:0] data_o,
  output logic              vld_o,
  input  logic              rdy_i
);
  logic              full;
  logic [DATA_W-1:0] word;

  assign bpc_rdy_o = ~full | rdy_i;
  assign vld_o     = full;
  assign data_o    = word;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      full <= 1'b0;
      word <= '0;
    end else if (bpc_vld_i && bpc_rdy_o) begin
      full <= 1'b1;
      word <= bpc_i;
    end else if (rdy_i) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/ebpc_out_reg.sv
// ebpc_out_reg - single-stage vld/rdy output register carrying data and last
module ebpc_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  input  logic         in_vld,
  output logic         in_rdy,
  output logic [W-1:0] data,
  output logic         last,
  output logic         vld,
  input  logic         rdy
);
  assign in_rdy = ~vld | rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      last <= 1'b0;
      data <= '0;
    end else if (clr) begin
      vld  <= 1'b0;
      last <= 1'b0;
    end else if (in_rdy) begin
      vld  <= in_vld;
      last <= in_vld & in_last;
      if (in_vld) data <= in_data;
    end
  end
endmodule

// File: rtl/zrle_decoder.sv
// zrle_decoder - expands ZRLE tokens into a zero/non-zero flag stream
// Token: MSB=1 is one non-zero symbol; MSB=0 is a run of (low bits + 1) zeros.
module zrle_decoder #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] znz_i,
  input  logic              znz_vld_i,
  output logic              znz_rdy_o,
  output logic              znz_o,
  output logic              vld_o,
  input  logic              rdy_i
);
  logic              busy;
  logic              tok_nz;
  logic [DATA_W-2:0] cnt;
  logic              tok_end;

  assign tok_end   = tok_nz | (cnt == '0);
  // The next token is taken in the same cycle the last symbol leaves, keeping 1 symbol/cycle.
  assign znz_rdy_o = ~busy | (rdy_i & tok_end);
  assign vld_o     = busy;
  assign znz_o     = tok_nz;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      busy   <= 1'b0;
      tok_nz <= 1'b0;
      cnt    <= '0;
    end else if (znz_vld_i && znz_rdy_o) begin
      busy   <= 1'b1;
      tok_nz <= znz_i[DATA_W-1];
      cnt    <= znz_i[DATA_W-2:0];
    end else if (busy && rdy_i) begin
      if (tok_end) busy <= 1'b0;
      else         cnt  <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/ebpc_frame_decoder.sv
// ebpc_frame_decoder - per-frame EBPC decode / raw bypass front end with abort and done status
module ebpc_frame_decoder #(
  parameter int DATA_W        = ebpc_pkg::DATA_W,
  parameter int LOG_MAX_WORDS = ebpc_pkg::LOG_MAX_WORDS
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_W-1:0]        bpc_i,
  input  logic                     bpc_vld_i,
  output logic                     bpc_rdy_o,
  input  logic [DATA_W-1:0]        znz_i,
  input  logic                     znz_vld_i,
  output logic                     znz_rdy_o,
  input  logic [LOG_MAX_WORDS-1:0] num_words_i,
  input  logic                     mode_i,
  input  logic                     num_words_vld_i,
  output logic                     num_words_rdy_o,
  input  logic                     abort_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     last_o,
  output logic                     vld_o,
  input  logic                     rdy_i,
  output logic                     done_o,
  output logic [LOG_MAX_WORDS:0]   done_cnt_o,
  output logic                     done_aborted_o
);
  import ebpc_pkg::*;

  if (DATA_W != ebpc_pkg::DATA_W) begin : g_width_check
    $error("ebpc_frame_decoder: DATA_W must equal ebpc_pkg::DATA_W");
  end

  localparam logic [LOG_MAX_WORDS:0] MAX_CNT = {1'b1, {LOG_MAX_WORDS{1'b0}}};

  frame_state_e             state;
  logic [LOG_MAX_WORDS-1:0] rem;
  logic [LOG_MAX_WORDS:0]   emitted, emitted_inc, done_cnt_q;
  logic                     done_q, done_aborted_q;
  logic                     run_ebpc, run_raw, flush, adv, can_push, push, abort_take, last_word;
  logic [DATA_W-1:0]        push_data, b_data;
  logic                     z_in_rdy, z_nz, z_vld, b_in_rdy, b_vld;

  assign run_ebpc    = (state == ST_RUN_EBPC);
  assign run_raw     = (state == ST_RUN_RAW);
  assign flush       = rst_i | (state == ST_DONE);
  assign last_word   = (rem == '0);
  assign emitted_inc = (emitted == MAX_CNT) ? emitted : emitted + 1'b1;

  always_comb begin
    can_push  = 1'b0;
    push_data = '0;
    if (run_raw) begin
      can_push  = bpc_vld_i & adv;
      push_data = bpc_i;
    end else if (run_ebpc) begin
      can_push  = z_vld & (~z_nz | b_vld) & adv;
      push_data = z_nz ? b_data : '0;
    end
  end

  // A final push beats a simultaneous abort so the frame still closes with last_o.
  assign push       = can_push & (~abort_i | last_word);
  assign abort_take = abort_i & (run_ebpc | run_raw) & ~push;

  assign num_words_rdy_o = ~rst_i & (state == ST_IDLE);
  assign znz_rdy_o       = ~rst_i & run_ebpc & z_in_rdy;
  assign bpc_rdy_o       = ~rst_i & (run_ebpc ? b_in_rdy : (run_raw & adv));
  assign done_o          = done_q;
  assign done_cnt_o      = done_cnt_q;
  assign done_aborted_o  = done_aborted_q;

  zrle_decoder #(.DATA_W(DATA_W)) u_zrle (
    .clk_i     (clk_i),
    .rst_ni    (~rst_i),
    .flush_i   (flush),
    .znz_i     (znz_i),
    .znz_vld_i (znz_vld_i & run_ebpc),
    .znz_rdy_o (z_in_rdy),
    .znz_o     (z_nz),
    .vld_o     (z_vld),
    .rdy_i     (push & run_ebpc)
  );

  bpc_decoder #(.DATA_W(DATA_W)) u_bpc (
    .clk_i     (clk_i),
    .rst_ni    (~rst_i),
    .clr_i     (flush),
    .bpc_i     (bpc_i),
    .bpc_vld_i (bpc_vld_i & run_ebpc),
    .bpc_rdy_o (b_in_rdy),
    .data_o    (b_data),
    .vld_o     (b_vld),
    .rdy_i     (push & run_ebpc & z_nz)
  );

  ebpc_out_reg #(.W(DATA_W)) u_out (
    .clk     (clk_i),
    .rst     (rst_i),
    .clr     (abort_take),
    .in_data (push_data),
    .in_last (last_word),
    .in_vld  (push),
    .in_rdy  (adv),
    .data    (data_o),
    .last    (last_o),
    .vld     (vld_o),
    .rdy     (rdy_i)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      rem            <= '0;
      emitted        <= '0;
      done_q         <= 1'b0;
      done_cnt_q     <= '0;
      done_aborted_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (num_words_vld_i) begin
            rem     <= num_words_i;
            emitted <= '0;
            state   <= (ebpc_mode_e'(mode_i) == EBPC_MODE_RAW) ? ST_RUN_RAW : ST_RUN_EBPC;
          end
        end
        ST_RUN_EBPC, ST_RUN_RAW: begin
          if (push) begin
            emitted <= emitted_inc;
            if (last_word) begin
              state          <= ST_DONE;
              done_q         <= 1'b1;
              done_cnt_q     <= emitted_inc;
              done_aborted_q <= 1'b0;
            end else begin
              rem <= rem - 1'b1;
            end
          end else if (abort_take) begin
            state          <= ST_DONE;
            done_q         <= 1'b1;
            done_cnt_q     <= emitted;
            done_aborted_q <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
